// File: rtl/se_arbiter_pkg.sv
// Shared definitions for the sound-effect arbiter.
//   SE_FREQ_W    default width of a channel frequency word (Hz)
//   SE_PHASE_K   default phase step per Hz for a 50 MHz clk with a 32-bit accumulator
//   SE_MAX_CH    widest request vector the priority encoder handles
//   state_t      arbiter FSM encoding
//   f_lowest_onehot  lowest set bit of a request vector, as one-hot
package se_arbiter_pkg;

   localparam int          SE_FREQ_W  = 16;
   localparam int unsigned SE_PHASE_K = 86;
   localparam int          SE_MAX_CH  = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

   // Two's-complement trick: v & -v isolates the lowest set bit (index 0 wins).
   function automatic logic [SE_MAX_CH-1:0] f_lowest_onehot(input logic [SE_MAX_CH-1:0] v);
      return v & (~v + SE_MAX_CH'(1));
   endfunction

endpackage

// File: rtl/se_arbiter_if.sv
// Request/grant bundle between the sound-effect generators and the arbiter.
//   enable    per-channel play request (level)
//   freq      per-channel frequency, channel n at [n*FREQ_W +: FREQ_W]
//   mute      global mute (level)
//   grant     one-hot granted channel, zero when idle
//   play      high while a channel is granted
//   freq_out  frequency of the granted channel, zero when idle
//   speaker   square-wave speaker drive
// master = generator side, slave = arbiter side.
interface se_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int FREQ_W = 16
);
   logic [NUM_CH-1:0]        enable;
   logic [NUM_CH*FREQ_W-1:0] freq;
   logic                     mute;
   logic [NUM_CH-1:0]        grant;
   logic                     play;
   logic [FREQ_W-1:0]        freq_out;
   logic                     speaker;

   modport master (
      output enable, freq, mute,
      input  grant, play, freq_out, speaker
   );

   modport slave (
      input  enable, freq, mute,
      output grant, play, freq_out, speaker
   );
endinterface

// File: rtl/se_arbiter_tone_dds.sv
// Phase-accumulator square-wave generator for the speaker pin.
//   i_clk      clock
//   i_rst      asynchronous active-high reset
//   i_clear    zero the accumulator (new grant, mute, idle)
//   i_run      advance the accumulator this cycle
//   i_freq     tone frequency in Hz
//   o_speaker  accumulator MSB
// A zero frequency gives a zero step, so the accumulator and the pin freeze.
module se_tone_dds #(
   parameter int          FREQ_W  = 16,
   parameter int          PHASE_W = 32,
   parameter int unsigned PHASE_K = 86
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_run,
   input  logic [FREQ_W-1:0] i_freq,
   output logic              o_speaker
);

   localparam int PROD_W = FREQ_W + 32;

   logic [PHASE_W-1:0] r_acc;
   logic [PROD_W-1:0]  w_prod;
   logic [PHASE_W-1:0] w_step;

   // The step wraps modulo 2^PHASE_W like the accumulator itself.
   assign w_prod = PROD_W'(i_freq) * PROD_W'(PHASE_K);
   assign w_step = w_prod[PHASE_W-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_run) begin
         r_acc <= r_acc + w_step;
      end
   end

   assign o_speaker = r_acc[PHASE_W-1];

endmodule

// File: rtl/se_arbiter.sv
// Shares one speaker tone path between NUM_CH sound-effect generators.
// Fixed priority (index 0 highest) with a minimum-hold window against
// preemption; a dropped grant is re-issued at once regardless of hold.
//   i_clk   clock
//   i_rst   asynchronous active-high reset
//   io_bus  se_arbiter_if.slave: requests, mute, grant/play/freq/speaker
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no channel granted, outputs zero, acc cleared
//   ST_PLAY | one channel granted, tone running
module se_arbiter
   import se_arbiter_pkg::*;
#(
   parameter int          NUM_CH   = 4,
   parameter int          FREQ_W   = SE_FREQ_W,
   parameter int          PHASE_W  = 32,
   parameter int unsigned PHASE_K  = SE_PHASE_K,
   parameter int unsigned MIN_HOLD = 250000
) (
   input  logic         i_clk,
   input  logic         i_rst,
   se_arbiter_if.slave  io_bus
);

   localparam int HOLD_W = $clog2(MIN_HOLD + 1);

   state_t              r_state;
   logic [NUM_CH-1:0]   r_grant;
   logic [FREQ_W-1:0]   r_freq;
   logic [HOLD_W-1:0]   r_hold;

   state_t              w_state_nxt;
   logic [NUM_CH-1:0]   w_grant_nxt;
   logic [HOLD_W-1:0]   w_hold_nxt;
   logic [FREQ_W-1:0]   w_freq_nxt;
   logic                w_clear;
   logic [SE_MAX_CH-1:0] w_low_ext;
   logic [NUM_CH-1:0]   w_low;
   logic                w_any;
   logic                w_keep;

   assign w_low_ext = f_lowest_onehot(SE_MAX_CH'(io_bus.enable));
   assign w_low     = w_low_ext[NUM_CH-1:0];
   assign w_any     = |io_bus.enable;
   assign w_keep    = |(r_grant & io_bus.enable);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_freq  <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_freq  <= w_freq_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_hold_nxt  = (r_hold != '0) ? r_hold - HOLD_W'(1) : '0;
      w_clear     = 1'b0;

      if (io_bus.mute) begin
         w_state_nxt = ST_IDLE;
         w_grant_nxt = '0;
         w_hold_nxt  = '0;
         w_clear     = 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  w_state_nxt = ST_PLAY;
                  w_grant_nxt = w_low;
                  w_hold_nxt  = HOLD_W'(MIN_HOLD);
                  w_clear     = 1'b1;
               end
            end
            ST_PLAY: begin
               if (w_keep) begin
                  // Granted channel is enabled, so a differing lowest bit is
                  // necessarily a higher-priority channel.
                  if ((w_low != r_grant) && (r_hold == '0)) begin
                     w_grant_nxt = w_low;
                     w_hold_nxt  = HOLD_W'(MIN_HOLD);
                     w_clear     = 1'b1;
                  end
               end else if (w_any) begin
                  w_grant_nxt = w_low;
                  w_hold_nxt  = HOLD_W'(MIN_HOLD);
                  w_clear     = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_grant_nxt = '0;
                  w_hold_nxt  = '0;
                  w_clear     = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
               w_hold_nxt  = '0;
               w_clear     = 1'b1;
            end
         endcase
      end
   end

   // Frequency follows the next grant so oFreq lines up with oGrant and
   // tracks live pitch sweeps of the granted channel.
   always_comb begin
      w_freq_nxt = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (w_grant_nxt[n]) begin
            w_freq_nxt = io_bus.freq[n*FREQ_W +: FREQ_W];
         end
      end
   end

   se_tone_dds #(
      .FREQ_W  (FREQ_W),
      .PHASE_W (PHASE_W),
      .PHASE_K (PHASE_K)
   ) u_dds (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_clear),
      .i_run     (r_state == ST_PLAY),
      .i_freq    (r_freq),
      .o_speaker (io_bus.speaker)
   );

   assign io_bus.grant    = r_grant;
   assign io_bus.play     = (r_state == ST_PLAY);
   assign io_bus.freq_out = r_freq;

endmodule

// File: tb/tb_se_arbiter.sv
module tb_se_arbiter;

   localparam int NCH  = 4;
   localparam int FW   = 16;
   localparam int PW   = 8;
   localparam int PK   = 1;
   localparam int HOLD = 8;

   logic clk;
   logic rst;

   se_arbiter_if #(.NUM_CH(NCH), .FREQ_W(FW)) bus ();

   se_arbiter #(
      .NUM_CH   (NCH),
      .FREQ_W   (FW),
      .PHASE_W  (PW),
      .PHASE_K  (PK),
      .MIN_HOLD (HOLD)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: granted channel index (-1 idle), hold, phase, latched freq
   int m_gnt  = -1;
   int m_hold = 0;
   int m_acc  = 0;
   int m_freq = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   function automatic int ch_freq(input int n);
      return int'(bus.freq[n*FW +: FW]);
   endfunction

   task automatic model_idle();
      m_gnt = -1; m_hold = 0; m_acc = 0; m_freq = 0;
   endtask

   task automatic model_step();
      int low;
      int nacc;
      low = -1;
      for (int n = NCH - 1; n >= 0; n--) if (bus.enable[n]) low = n;
      if (rst || bus.mute) begin
         model_idle();
      end else if (m_gnt < 0) begin
         if (low >= 0) begin m_gnt = low; m_hold = HOLD; m_acc = 0; end
      end else begin
         nacc = (m_acc + m_freq * PK) % (1 << PW);
         if (bus.enable[m_gnt]) begin
            if (low < m_gnt && m_hold == 0) begin
               m_gnt = low; m_hold = HOLD; m_acc = 0;
            end else begin
               m_hold = (m_hold > 0) ? m_hold - 1 : 0;
               m_acc  = nacc;
            end
         end else if (low >= 0) begin
            m_gnt = low; m_hold = HOLD; m_acc = 0;
         end else begin
            model_idle();
         end
      end
      m_freq = (m_gnt >= 0) ? ch_freq(m_gnt) : 0;
   endtask

   task automatic compare_model();
      chk("grant",   32'(bus.grant),    (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
      chk("play",    32'(bus.play),     32'(m_gnt >= 0));
      chk("freq",    32'(bus.freq_out), 32'(m_freq));
      chk("speaker", 32'(bus.speaker),  32'(m_acc >= (1 << (PW - 1))));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_model();
   endtask

   task automatic set_freq(input int n, input int f);
      bus.freq[n*FW +: FW] = FW'(f);
   endtask

   initial begin
      rst        = 1'b1;
      bus.enable = '0;
      bus.freq   = '0;
      bus.mute   = 1'b0;
      model_idle();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("reset_grant", 32'(bus.grant), 32'd0);
      chk("reset_spk",   32'(bus.speaker), 32'd0);

      // 1: ch1 at 16 -> 8 low / 8 high square wave
      set_freq(1, 16);
      bus.enable = 4'b0010;
      tick();
      chk("t1_grant", 32'(bus.grant),    32'b0010);
      chk("t1_en",    32'(bus.play),     32'd1);
      chk("t1_freq",  32'(bus.freq_out), 32'd16);
      for (int k = 1; k < 32; k++) begin
         tick();
         chk("t1_wave", 32'(bus.speaker), 32'((k % 16) >= 8));
      end

      // 2: ch2 playing, ch0 requests 3 cycles in; switch at grant+9
      bus.enable = 4'b0000;
      tick();
      set_freq(2, 50);
      set_freq(0, 32);
      bus.enable = 4'b0100;
      tick();
      chk("t2_grant0", 32'(bus.grant), 32'b0100);
      for (int i = 1; i <= 9; i++) begin
         if (i == 3) bus.enable = 4'b0101;
         tick();
         chk("t2_hold", 32'(bus.grant), (i < 9) ? 32'b0100 : 32'b0001);
      end

      // 3: ch3 never preempts ch0; ch0 drop hands over immediately
      set_freq(3, 7);
      bus.enable = 4'b1001;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t3_keep", 32'(bus.grant), 32'b0001);
      end
      bus.enable = 4'b1000;
      tick();
      chk("t3_drop", 32'(bus.grant), 32'b1000);

      // 4: ch1 drops as ch2 asserts
      bus.enable = 4'b0010;
      repeat (12) tick();
      bus.enable = 4'b0100;
      tick();
      chk("t4_grant", 32'(bus.grant),   32'b0100);
      chk("t4_spk",   32'(bus.speaker), 32'd0);

      // 5: mute clears everything, unmute regrants lowest
      bus.enable = 4'b0110;
      repeat (14) tick();
      bus.mute = 1'b1;
      tick();
      chk("t5_grant", 32'(bus.grant),    32'd0);
      chk("t5_en",    32'(bus.play),     32'd0);
      chk("t5_freq",  32'(bus.freq_out), 32'd0);
      repeat (3) tick();
      bus.mute = 1'b0;
      tick();
      chk("t5_regrant", 32'(bus.grant), 32'b0010);

      // 6: async reset mid-tone
      set_freq(1, 20);
      repeat (9) tick();
      #2 rst = 1'b1;
      #1;
      model_idle();
      chk("t6_grant", 32'(bus.grant),    32'd0);
      chk("t6_en",    32'(bus.play),     32'd0);
      chk("t6_freq",  32'(bus.freq_out), 32'd0);
      chk("t6_spk",   32'(bus.speaker),  32'd0);
      bus.enable = 4'b0000;
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("t6_idle", 32'(bus.play), 32'd0);

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(5) == 0) bus.enable = NCH'($urandom);
         if ($urandom_range(24) == 0) bus.mute = ~bus.mute;
         if ($urandom_range(7) == 0)
            set_freq(int'($urandom_range(NCH - 1)),
                     ($urandom_range(5) == 0) ? 0 : int'($urandom_range(300)));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
